simpleio_input_cond: RTL and testbench

//  Input end of the onboard-devices port. Samples raw board switches and push-buttons, then synchronizes
//  and debounces them, and drives clean switches/keys levels into the simpleio register block (read at $04).

---
 rtl/simpleio_pkg.sv | 24 ++
 rtl/simpleio_debounce_bit.sv | 45 ++++
 rtl/simpleio_input_cond.sv | 85 ++++++++
 tb/tb_simpleio_input_cond.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/simpleio_pkg.sv
// Shared constants for the simpleio onboard-devices port: sizes, debounce defaults, register map.
package simpleio_pkg;

   localparam int SIMPLEIO_N_SW      = 4;
   localparam int SIMPLEIO_N_KEY     = 4;
   localparam int SIMPLEIO_TICK_DIV  = 50000;
   localparam int SIMPLEIO_DEB_TICKS = 8;

   typedef enum logic [7:0] {
      SIMPLEIO_REG_INPUT    = 8'h04,
      SIMPLEIO_REG_EVT_PEND = 8'h08,
      SIMPLEIO_REG_IRQ_EN   = 8'h0C
   } simpleio_reg_e;

   // One spare bit so DEB_TICKS-1 always fits, including DEB_TICKS=1.
   function automatic int deb_cnt_w(input int deb_ticks);
      return $clog2(deb_ticks) + 1;
   endfunction

   function automatic int presc_w(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/simpleio_debounce_bit.sv
// One input bit: 2-FF synchronizer followed by a tick-paced debounce counter.
module simpleio_debounce_bit
   import simpleio_pkg::*;
#(
   parameter int DEB_TICKS = SIMPLEIO_DEB_TICKS
) (
   input  logic clk_in,
   input  logic rst,
   input  logic rst_val,
   input  logic tick,
   input  logic raw,
   output logic clean
);

   localparam int            CW       = deb_cnt_w(DEB_TICKS);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk_in) begin
      if (rst) begin
         sync1 <= rst_val;
         sync2 <= rst_val;
         clean <= rst_val;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         // Any cycle of agreement restarts the count, even between ticks.
         if (sync2 == clean) begin
            cnt <= '0;
         end else if (tick) begin
            if (cnt == CNT_LAST) begin
               clean <= sync2;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/simpleio_input_cond.sv
// Conditions board switches/buttons into clean levels, latches key presses as pending
// events and raises a maskable interrupt.
module simpleio_input_cond
   import simpleio_pkg::*;
#(
   parameter int N_SW      = SIMPLEIO_N_SW,
   parameter int N_KEY     = SIMPLEIO_N_KEY,
   parameter int TICK_DIV  = SIMPLEIO_TICK_DIV,
   parameter int DEB_TICKS = SIMPLEIO_DEB_TICKS
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic [N_SW-1:0]  raw_sw,
   input  logic [N_KEY-1:0] raw_key_n,
   input  logic [N_KEY-1:0] irq_en,
   input  logic [N_KEY-1:0] evt_clr,
   output logic [N_SW-1:0]  switches,
   output logic [N_KEY-1:0] keys,
   output logic [N_KEY-1:0] press,
   output logic [N_KEY-1:0] pend,
   output logic             irq
);

   localparam int            PW         = presc_w(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0]    presc;
   logic             tick;
   logic [N_KEY-1:0] keys_d;

   // With TICK_DIV=1 the prescaler is pinned at 0 and tick is always high.
   assign tick = (presc == PRESC_LAST);

   always_ff @(posedge clk_in) begin
      if (rst) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + 1'b1;
      end
   end

   for (genvar i = 0; i < N_SW; i++) begin : g_sw
      simpleio_debounce_bit #(
         .DEB_TICKS (DEB_TICKS)
      ) u_deb (
         .clk_in  (clk_in),
         .rst     (rst),
         .rst_val (1'b0),
         .tick    (tick),
         .raw     (raw_sw[i]),
         .clean   (switches[i])
      );
   end

   for (genvar i = 0; i < N_KEY; i++) begin : g_key
      simpleio_debounce_bit #(
         .DEB_TICKS (DEB_TICKS)
      ) u_deb (
         .clk_in  (clk_in),
         .rst     (rst),
         .rst_val (1'b1),
         .tick    (tick),
         .raw     (raw_key_n[i]),
         .clean   (keys[i])
      );
   end

   // Keys are active-low, so a press is a falling edge of the clean level.
   always_ff @(posedge clk_in) begin
      if (rst) begin
         keys_d <= '1;
         press  <= '0;
         pend   <= '0;
         irq    <= 1'b0;
      end else begin
         keys_d <= keys;
         press  <= keys_d & ~keys;
         pend   <= (pend & ~evt_clr) | press;
         irq    <= |(pend & irq_en);
      end
   end

endmodule

// File: tb/tb_simpleio_input_cond.sv
// Directed plus randomized bench for simpleio_input_cond against a cycle-level behavioural model.
module tb_simpleio_input_cond;

   localparam int TD = 4;
   localparam int DT = 3;

   logic       clk_in = 1'b0;
   logic       rst;
   logic [3:0] raw_sw, raw_key_n, irq_en, evt_clr;
   logic [3:0] switches, keys, press, pend;
   logic       irq;

   int checks = 0;
   int errors = 0;

   // Model: bits [3:0] switches, [7:4] keys
   logic [7:0] m_h0, m_h1, m_clean;
   int         m_mis[8];
   int         m_ncyc;
   logic [3:0] m_keys_d, m_press, m_pend;
   logic       m_irq;

   simpleio_input_cond #(
      .N_SW(4), .N_KEY(4), .TICK_DIV(TD), .DEB_TICKS(DT)
   ) dut (
      .clk_in(clk_in), .rst(rst), .raw_sw(raw_sw), .raw_key_n(raw_key_n),
      .irq_en(irq_en), .evt_clr(evt_clr), .switches(switches), .keys(keys),
      .press(press), .pend(pend), .irq(irq)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge();
      logic [7:0] s, cl_old;
      logic       tk, irq_new;
      logic [3:0] press_new;
      if (rst) begin
         m_h0 = 8'hF0; m_h1 = 8'hF0; m_clean = 8'hF0;
         for (int b = 0; b < 8; b++) m_mis[b] = 0;
         m_ncyc = 0; m_keys_d = 4'hF; m_press = 0; m_pend = 0; m_irq = 0;
      end else begin
         s  = m_h1;
         tk = (m_ncyc % TD) == TD - 1;
         cl_old = m_clean;
         // A level flips after DT ticks during which the synced pin disagreed continuously
         for (int b = 0; b < 8; b++) begin
            if (s[b] == m_clean[b]) m_mis[b] = 0;
            else if (tk) begin
               m_mis[b]++;
               if (m_mis[b] == DT) begin
                  m_clean[b] = s[b];
                  m_mis[b] = 0;
               end
            end
         end
         press_new = m_keys_d & ~cl_old[7:4];
         m_keys_d  = cl_old[7:4];
         irq_new   = |(m_pend & irq_en);
         m_pend    = (m_pend & ~evt_clr) | m_press;
         m_press   = press_new;
         m_irq     = irq_new;
         m_h1 = m_h0;
         m_h0 = {raw_key_n, raw_sw};
         m_ncyc++;
      end
   endtask

   task automatic cycle();
      @(posedge clk_in);
      model_edge();
      #1;
      check("m_switches", 32'(switches), 32'(m_clean[3:0]));
      check("m_keys",     32'(keys),     32'(m_clean[7:4]));
      check("m_press",    32'(press),    32'(m_press));
      check("m_pend",     32'(pend),     32'(m_pend));
      check("m_irq",      32'(irq),      32'(m_irq));
   endtask

   initial begin
      int lat, npress, bad;
      rst = 1; raw_sw = 0; raw_key_n = 0; irq_en = 0; evt_clr = 0;

      // 1: reset with all keys held pressed
      repeat (3) cycle();
      check("t1_keys_rst", 32'(keys), 32'hF);
      check("t1_sw_rst",   32'(switches), 32'h0);
      check("t1_pend_rst", 32'(pend), 32'h0);
      check("t1_irq_rst",  32'(irq), 32'h0);
      rst = 0;
      lat = 0;
      while (keys !== 4'h0 && lat < 40) begin cycle(); lat++; end
      check("t1_fall_lat", 32'(lat), 32'd12);
      raw_key_n = 4'hF;
      repeat (20) cycle();
      evt_clr = 4'hF; cycle(); evt_clr = 0;
      check("t1_pend_clr", 32'(pend), 32'h0);

      // 2: clean press at random tick phase
      repeat ($urandom_range(0, 7)) cycle();
      raw_key_n[0] = 0;
      lat = 0;
      while (keys[0] !== 1'b0 && lat < 30) begin cycle(); lat++; end
      check("t2_lat_window", 32'(lat >= 11 && lat <= 14), 32'd1);
      cycle();
      check("t2_press_hi", 32'(press), 32'h1);
      cycle();
      check("t2_press_lo", 32'(press), 32'h0);
      check("t2_pend", 32'(pend[0]), 32'd1);

      // 3: bounce on key1 ending released, then ending pressed
      npress = 0; bad = 0;
      for (int k = 0; k < 40; k++) begin
         if (k % 5 == 0) raw_key_n[1] = ~raw_key_n[1];
         cycle();
         npress += int'(press[1]);
         bad |= int'(keys[1] !== 1'b1);
      end
      repeat (20) begin cycle(); npress += int'(press[1]); bad |= int'(keys[1] !== 1'b1); end
      check("t3_no_flip", 32'(bad), 32'd0);
      check("t3_no_press", 32'(npress), 32'd0);
      npress = 0;
      for (int k = 0; k < 35; k++) begin
         if (k % 5 == 0) raw_key_n[1] = ~raw_key_n[1];
         cycle();
         npress += int'(press[1]);
      end
      repeat (30) begin cycle(); npress += int'(press[1]); end
      check("t3_one_press", 32'(npress), 32'd1);
      raw_key_n[1] = 1;
      repeat (20) cycle();

      // 4: interrupt and clear
      irq_en = 4'b0001;
      evt_clr = 4'hF; cycle(); evt_clr = 0;
      raw_key_n[0] = 1;
      repeat (20) cycle();
      check("t4_irq_idle", 32'(irq), 32'd0);
      raw_key_n[0] = 0;
      lat = 0;
      while (pend[0] !== 1'b1 && lat < 30) begin cycle(); lat++; end
      check("t4_pend_set", 32'(pend[0]), 32'd1);
      check("t4_irq_lag", 32'(irq), 32'd0);
      cycle();
      check("t4_irq_on", 32'(irq), 32'd1);
      evt_clr = 4'b0001; cycle(); evt_clr = 0;
      check("t4_pend_cleared", 32'(pend[0]), 32'd0);
      cycle();
      check("t4_irq_off", 32'(irq), 32'd0);
      raw_key_n[0] = 1;
      repeat (20) cycle();
      raw_key_n[0] = 0;
      lat = 0;
      while (press[0] !== 1'b1 && lat < 30) begin cycle(); lat++; end
      check("t4_press_seen", 32'(press[0]), 32'd1);
      evt_clr = 4'b0001; cycle(); evt_clr = 0;
      check("t4_set_wins", 32'(pend[0]), 32'd1);
      evt_clr = 4'hF; cycle(); evt_clr = 0;
      raw_key_n[0] = 1; irq_en = 0;
      repeat (20) cycle();

      // 5: simultaneous steps on switches and keys
      raw_sw = 4'b1010; raw_key_n = 4'b0110;
      lat = 0;
      while (switches === 4'h0 && keys === 4'hF && lat < 30) begin cycle(); lat++; end
      check("t5_sw", 32'(switches), 32'hA);
      check("t5_keys", 32'(keys), 32'h6);
      cycle();
      check("t5_press", 32'(press), 32'h9);
      cycle();
      check("t5_press_lo", 32'(press), 32'h0);
      raw_sw = 0; raw_key_n = 4'hF;
      repeat (20) cycle();
      evt_clr = 4'hF; cycle(); evt_clr = 0;

      // 6: reset after 2 of 3 ticks of a key0 press
      raw_key_n[0] = 0;
      lat = 0;
      while (m_mis[4] != 2 && lat < 30) begin cycle(); lat++; end
      check("t6_reached_2", 32'(m_mis[4]), 32'd2);
      rst = 1; cycle(); cycle();
      check("t6_keys_rst", 32'(keys), 32'hF);
      rst = 0;
      lat = 0;
      while (keys[0] !== 1'b0 && lat < 40) begin cycle(); lat++; end
      check("t6_full_relat", 32'(lat), 32'd12);
      raw_key_n = 4'hF;
      repeat (20) cycle();

      // Random pins, clears and enables checked every cycle by the model
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 11) == 0) raw_sw[$urandom_range(0, 3)] ^= 1'b1;
         if ($urandom_range(0, 9) == 0) raw_key_n[$urandom_range(0, 3)] ^= 1'b1;
         evt_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
         if ($urandom_range(0, 199) == 0) irq_en = 4'($urandom);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
